// File: rtl/if_id_fetch_stage.sv
// Instruction fetch stage with IF/ID pipeline register, one-entry skid buffer,
// flush and delay-slot annul handling; drives the PC/nPC load enable.
module if_id_fetch_stage #(
  parameter int                 ADDR_W  = 32,
  parameter int                 INSTR_W = 32,
  parameter logic [INSTR_W-1:0] NOP     = 32'h01000000
) (
  input  logic               clk,
  input  logic               clr,
  input  logic [ADDR_W-1:0]  pc_in,
  output logic               pc_le,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               imem_ready,
  input  logic               stall,
  input  logic               flush,
  input  logic               annul,
  output logic [INSTR_W-1:0] id_instr,
  output logic [ADDR_W-1:0]  id_pc,
  output logic               id_valid
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 r_annul_pend;
  logic [INSTR_W-1:0]   r_skid_instr;
  logic [ADDR_W-1:0]    r_skid_pc;

  logic                 w_flush;
  logic                 w_id_load;
  logic                 w_skid_load;
  logic [INSTR_W-1:0]   w_id_src_instr;
  logic [ADDR_W-1:0]    w_id_src_pc;

  // NOTE: state register uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk) begin
    if (!clr) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    w_state_nxt    = r_state;
    w_flush        = 1'b0;
    w_id_load      = 1'b0;
    w_skid_load    = 1'b0;
    w_id_src_instr = imem_rdata;
    w_id_src_pc    = pc_in;
    imem_req       = 1'b0;
    pc_le          = 1'b0;
    case (r_state)
      S_IDLE: w_state_nxt = S_REQ;
      S_REQ: begin
        imem_req = 1'b1;
        pc_le    = imem_ready | flush;
        if (flush) begin
          w_flush     = 1'b1;
          w_state_nxt = S_REQ;
        end else if (imem_ready && !stall) begin
          w_id_load = 1'b1;
        end else if (imem_ready && stall) begin
          w_skid_load = 1'b1;
          w_state_nxt = S_HOLD;
        end
      end
      S_HOLD: begin
        pc_le          = flush;
        w_id_src_instr = r_skid_instr;
        w_id_src_pc    = r_skid_pc;
        if (flush) begin
          w_flush     = 1'b1;
          w_state_nxt = S_REQ;
        end else if (!stall) begin
          w_id_load   = 1'b1;
          w_state_nxt = S_REQ;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // IF/ID register and annul tracking; a pending annul consumes the next ID
  // write, while a fresh annul arriving with that write targets the one after.
  always_ff @(posedge clk) begin
    if (!clr) begin
      id_instr     <= NOP;
      id_pc        <= '0;
      id_valid     <= 1'b0;
      r_annul_pend <= 1'b0;
    end else if (w_flush) begin
      id_instr     <= NOP;
      id_valid     <= 1'b0;
      r_annul_pend <= 1'b0;
    end else if (w_id_load) begin
      id_pc        <= w_id_src_pc;
      id_instr     <= r_annul_pend ? NOP : w_id_src_instr;
      id_valid     <= !r_annul_pend;
      r_annul_pend <= annul;
    end else begin
      r_annul_pend <= r_annul_pend | annul;
    end
  end

  // NOTE: the skid is pure data with no reset; its contents are only read in
  // HOLD, which is reachable solely through a skid load, so "empty" is the state.
  always_ff @(posedge clk) begin
    if (w_skid_load) begin
      r_skid_instr <= imem_rdata;
      r_skid_pc    <= pc_in;
    end
  end

  assign imem_addr = pc_in;

endmodule
